seq_mult_pp: RTL and testbench

Parametrised sequential multiplier that forms a WIDTH×WIDTH product by iterating digit-by-digit partial products (DIGIT×DIGIT) into a shifted 2·WIDTH accumulator. It is the general successor to the fixed 4×4 shift-and-add datapath: arbitrary operand width and digit size, with an integrated controller and start/busy/done handshake. It sits between operand-producing logic and any consumer of the 2·WIDTH result.

---
 rtl/seq_mult_pp_if.sv | 32 +++
 rtl/seq_mult_pp.sv | 182 ++++++++++++++++++
 tb/tb_seq_mult_pp.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pp_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_pp_if
//  Purpose  : start/busy/done handshake and operand/result bus for
//             seq_mult_pp. WIDTH must match the multiplier's WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_mult_pp_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Operand producer side
  modport master (
    output start, a, b,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface : seq_mult_pp_if
`default_nettype wire

// File: rtl/seq_mult_pp.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_pp
//  Purpose  : Sequential WIDTH x WIDTH multiplier. One DIGIT x DIGIT partial
//             product per cycle is shifted into a 2*WIDTH accumulator, K*K
//             cycles per operation (K = WIDTH/DIGIT), with a start/busy/done
//             handshake.
//  Options  : define SEQ_MULT_SIGNED_EN for two's-complement operands/result.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult_pp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  seq_mult_pp_if.slave  bus
);

  localparam int K  = WIDTH / DIGIT;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW);
  localparam logic [IW-1:0] C_LAST = IW'(K - 1);

  // Reject configurations where the digits do not tile the operand
  generate
    if ((WIDTH % DIGIT) != 0) begin : g_param_check
      $error("seq_mult_pp: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQ_MULT_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] ra_shift, rb_shift;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [PW-1:0]    pp_ext;
  logic [PW-1:0]    acc_sum;
  logic [SW-1:0]    sh_a, sh_b, sh_pp;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [PW-1:0]    final_val;

  // Current digit pair partial product, aligned to weight DIGIT*(i+j)
  always_comb begin
    sh_a     = SW'(DIGIT) * SW'(i_q);
    sh_b     = SW'(DIGIT) * SW'(j_q);
    sh_pp    = sh_a + sh_b;
    ra_shift = ra_q >> sh_a;
    rb_shift = rb_q >> sh_b;
    a_dig    = ra_shift[DIGIT-1:0];
    b_dig    = rb_shift[DIGIT-1:0];
    pp       = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
    pp_ext   = {{(PW-2*DIGIT){1'b0}}, pp} << sh_pp;
    acc_sum  = acc_q + pp_ext;
  end

  // Operand conditioning at capture and result conditioning at completion
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    cap_a     = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    cap_b     = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    final_val = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
`else
    cap_a     = bus.a;
    cap_b     = bus.b;
    final_val = acc_sum;
`endif
  end

  // Controller next-state: digit iteration order and handshake outputs
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ra_d    = cap_a;
          rb_d    = cap_b;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        if (i_q == C_LAST) begin
          i_d = '0;
          if (j_q == C_LAST) begin
            // Last pair: publish the completed sum directly
            product_d = final_val;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule : seq_mult_pp
`default_nettype wire

// File: tb/tb_seq_mult_pp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mult_pp
//  Purpose  : Directed bench for seq_mult_pp (WIDTH=8/DIGIT=2 and
//             WIDTH=12/DIGIT=3 instances). Expectations follow
//             SEQ_MULT_SIGNED_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_pp;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;

  seq_mult_pp_if #(.WIDTH(8))  bus8  ();
  seq_mult_pp_if #(.WIDTH(12)) bus12 ();

  seq_mult_pp #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  seq_mult_pp #(.WIDTH(12), .DIGIT(3)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done cycles of the 8-bit instance, sampled mid-cycle
  always @(negedge clk) begin
    if (bus8.done) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] pu;   // unsigned expectation
    logic [15:0] ps;   // two's-complement expectation
    int          inj;  // RUN cycle at which a stray start is pulsed (0 = none)
  } vec_t;

  // Entered at #1 after a posedge with the DUT idle; leaves one cycle after done
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv,
                       input logic [15:0] exp, input int inj, input string tag);
    logic [15:0] prev;
    int n, busy_cyc, dc0;
    bit hold_ok, got;
    prev = bus8.product;
    dc0  = done_cnt;
    bus8.a = ta; bus8.b = tbv; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = ~ta; bus8.b = ~tbv;
    check({tag, "_busy_accept"}, 32'(bus8.busy), 32'd1);
    busy_cyc = 1; hold_ok = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (inj != 0 && n == inj) begin
        bus8.start = 1'b1; bus8.a = 8'd7; bus8.b = 8'd9;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      n = n + 1;
      if (bus8.busy) busy_cyc = busy_cyc + 1;
      if (bus8.done) got = 1'b1;
      else if (bus8.product !== prev) hold_ok = 1'b0;
    end
    bus8.start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_product"}, 32'(bus8.product), 32'(exp));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd17);
    check({tag, "_product_held"}, 32'(hold_ok), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, "_product_after"}, 32'(bus8.product), 32'(exp));
    if (inj != 0) begin
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_stray_start_busy"}, 32'(bus8.busy), 32'd0);
      check({tag, "_stray_start_done"}, 32'(done_cnt - dc0), 32'd1);
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [15:0] exp;
    logic [23:0] exp12;
    int n, dc0;
    bit got;

    checks = 0; failures = 0; done_cnt = 0;
    vecs[0] = '{8'd13,  8'd11,  16'd143,   16'd143,   0};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, 16'h0001,  0};
    vecs[2] = '{8'd0,   8'd200, 16'd0,     16'd0,     0};
    vecs[3] = '{8'd3,   8'd4,   16'd12,    16'd12,    5};
    vecs[4] = '{8'd253, 8'd5,   16'd1265,  16'hFFF1,  0};
    vecs[5] = '{8'd128, 8'd128, 16'd16384, 16'd16384, 0};
    vecs[6] = '{8'd128, 8'd127, 16'd16256, 16'hC080,  0};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus12.start = 1'b0; bus12.a = '0; bus12.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus8.busy), 32'd0);
    check("reset_done", 32'(bus8.done), 32'd0);
    check("reset_product", 32'(bus8.product), 32'd0);
    check("reset12_busy", 32'(bus12.busy), 32'd0);
    check("reset12_product", 32'(bus12.product), 32'd0);
    rst = 1'b0;

    // Back-to-back table: each op is accepted in the first IDLE cycle
    for (int k = 0; k < 7; k++) begin
`ifdef SEQ_MULT_SIGNED_EN
      exp = vecs[k].ps;
`else
      exp = vecs[k].pu;
`endif
      do_op(vecs[k].a, vecs[k].b, exp, vecs[k].inj, $sformatf("vec%0d", k));
    end

    // Abort mid-RUN with reset: no done may follow
    bus8.a = 8'd100; bus8.b = 8'd100; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_running", 32'(bus8.busy), 32'd1);
    dc0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_product", 32'(bus8.product), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    check("abort_idle", 32'(bus8.busy), 32'd0);
    do_op(8'd6, 8'd7, 16'd42, 0, "after_abort");

    // Reset and start together: reset wins and the start is lost
    rst = 1'b1; bus8.a = 8'd5; bus8.b = 8'd5; bus8.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus8.start = 1'b0;
    check("rst_start_busy", 32'(bus8.busy), 32'd0);
    @(posedge clk); #1;
    check("rst_start_busy_later", 32'(bus8.busy), 32'd0);
    check("rst_start_product", 32'(bus8.product), 32'd0);

    // WIDTH=12, DIGIT=3 instance: K=4, 16 RUN cycles
    bus12.a = 12'd4095; bus12.b = 12'd4095; bus12.start = 1'b1;
    @(posedge clk); #1;
    bus12.start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n = n + 1;
      if (bus12.done) got = 1'b1;
    end
`ifdef SEQ_MULT_SIGNED_EN
    exp12 = 24'd1;
`else
    exp12 = 24'd16769025;
`endif
    check("w12_latency", 32'(n), 32'd16);
    check("w12_product", 32'(bus12.product), 32'(exp12));
    @(posedge clk); #1;
    check("w12_idle", 32'(bus12.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_mult_pp
`default_nettype wire
